page_table_8b: RTL and testbench
================================

Name: page_table_8b

Overview:
- Small in-memory page table model that sits behind a TLB.
- Holds 16 six-bit translation entries, written through a one-cycle insert port.
- Serves 3-bit virtual page lookups with a fixed multi-cycle "walk" latency.
- Signals completion with a one-cycle LOOKUP_COMPLETE pulse and a held LOOKUP_RETURN value.

Parameters:
- WALK_LATENCY, 4, cycles from the clock edge that accepts a request to the edge that asserts LOOKUP_COMPLETE (legal range 1..15).
- LOOKUP_HALF, 1, fixed MSB of the 4-bit table index used by lookups; lookup index = {LOOKUP_HALF, LOOKUP_ADDR}.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- LOOKUP_RQST  input  1  lookup request, sampled on rising edge.
- LOOKUP_ADDR  input  3  virtual page number to translate.
- LOOKUP_COMPLETE  output  1  one-cycle pulse when LOOKUP_RETURN is valid.
- LOOKUP_RETURN  output  6  translation result; registered and held.
- PT_INSERT_RQST  input  1  write enable for the table.
- PT_INSERT_INDX  input  4  table index to write (0..15).
- PT_INSERT_ENTRY  input  6  data to write.

Behaviour:
- Reset (rst=1 at a rising edge):
  - all 16 entries become 6'b000000;
  - FSM goes to IDLE and the walk counter clears;
  - LOOKUP_COMPLETE=0 and LOOKUP_RETURN=6'b000000.
  - Reset has priority over everything, including a walk in progress, which is aborted with no completion pulse.
- Insert:
  - at a rising edge with PT_INSERT_RQST=1 and rst=0, entry[PT_INSERT_INDX] takes PT_INSERT_ENTRY;
  - no handshake; accepted every cycle, including during a walk.
- Lookup FSM with states IDLE, WALK:
  - IDLE, LOOKUP_RQST=1 at a rising edge: latch LOOKUP_ADDR, set cnt=WALK_LATENCY-1, go to WALK.
    - If WALK_LATENCY=1, skip WALK and complete on the next edge (see the completion rule).
  - WALK, cnt>0: decrement cnt.
  - WALK, cnt=0: at this edge, load LOOKUP_RETURN with entry[{LOOKUP_HALF, latched addr}], set LOOKUP_COMPLETE=1, return to IDLE.
  - LOOKUP_COMPLETE drops to 0 on the following edge.
  - Net latency: a request sampled at edge N produces COMPLETE high during the cycle following edge N+WALK_LATENCY.
- LOOKUP_RQST while in WALK, or on the edge that completes, is ignored and is not queued.
  - The requester must re-assert the request after seeing COMPLETE.
- A request held high continuously starts a new walk on the first IDLE edge, i.e. the edge after COMPLETE rises.
- The table is read at completion time, not at request time, so inserts made during a walk are visible.
- Simultaneous insert to the walked index on the completing edge: the new PT_INSERT_ENTRY value is forwarded to LOOKUP_RETURN.
- LOOKUP_RETURN holds its value between completions. LOOKUP_ADDR changes after acceptance have no effect.
- Entries outside the lookup half (index MSB != LOOKUP_HALF) are writable but never returned.

Test Plan:
- Reset, then lookup LOOKUP_ADDR=3'b101 for one cycle:
  - COMPLETE pulses exactly once, 4 edges after acceptance;
  - LOOKUP_RETURN=6'b000000.
- Insert index 15 with 6'b101010 (one-cycle PT_INSERT_RQST), then lookup 3'b111:
  - LOOKUP_RETURN=6'b101010 with a single-cycle COMPLETE;
  - the value is held afterwards.
- Insert index 13 with 6'b000111, lookup 3'b101, then insert index 13 with 6'b111000 two cycles into the walk:
  - return is 6'b111000.
- Same-edge case: insert index 12 with 6'b010101 on the completing edge of a lookup of 3'b100:
  - return is 6'b010101.
- Assert LOOKUP_RQST with addr 3'b111 during a walk of 3'b101:
  - it is ignored, with exactly one COMPLETE and return = entry 13;
  - holding RQST high continuously yields back-to-back walks separated by one idle cycle.
- Assert rst mid-walk:
  - no COMPLETE follows;
  - LOOKUP_RETURN=0 and all entries read back 0 on subsequent lookups.

Source files
------------

// File: rtl/page_table_8b.sv
// Sixteen-entry, six-bit page table behind a TLB: one-cycle inserts and fixed-latency
// lookups into the upper or lower half selected by LOOKUP_HALF.
module page_table_8b #(
   parameter int WALK_LATENCY = 4,
   parameter bit LOOKUP_HALF  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       LOOKUP_RQST,
   input  logic [2:0] LOOKUP_ADDR,
   output logic       LOOKUP_COMPLETE,
   output logic [5:0] LOOKUP_RETURN,
   input  logic       PT_INSERT_RQST,
   input  logic [3:0] PT_INSERT_INDX,
   input  logic [5:0] PT_INSERT_ENTRY
);

   localparam logic [3:0] CNT_INIT = 4'(WALK_LATENCY - 1);

   typedef enum logic {
      IDLE,
      WALK
   } state_t;

   state_t     state;
   logic [3:0] walk_cnt;
   logic [2:0] walk_addr;
   logic [5:0] entry_mem [16];
   logic [3:0] walk_indx;
   logic       insert_hit;

   assign walk_indx  = {LOOKUP_HALF, walk_addr};
   assign insert_hit = PT_INSERT_RQST && (PT_INSERT_INDX == walk_indx);

   // A write landing on the walked entry at the completing edge wins over the stored copy.
   function automatic logic [5:0] read_fwd(input logic       hit,
                                           input logic [5:0] ins_val,
                                           input logic [5:0] mem_val);
      return hit ? ins_val : mem_val;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         walk_cnt        <= '0;
         walk_addr       <= '0;
         LOOKUP_COMPLETE <= 1'b0;
         LOOKUP_RETURN   <= '0;
         for (int i = 0; i < 16; i++) begin
            entry_mem[i] <= '0;
         end
      end else begin
         if (PT_INSERT_RQST) begin
            entry_mem[PT_INSERT_INDX] <= PT_INSERT_ENTRY;
         end
         LOOKUP_COMPLETE <= 1'b0;
         case (state)
            IDLE: begin
               // A latency of 1 lands in WALK with a zero count, completing on the next edge.
               if (LOOKUP_RQST) begin
                  walk_addr <= LOOKUP_ADDR;
                  walk_cnt  <= CNT_INIT;
                  state     <= WALK;
               end
            end
            WALK: begin
               if (walk_cnt != 4'd0) begin
                  walk_cnt <= walk_cnt - 4'd1;
               end else begin
                  LOOKUP_RETURN   <= read_fwd(insert_hit, PT_INSERT_ENTRY,
                                              entry_mem[walk_indx]);
                  LOOKUP_COMPLETE <= 1'b1;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_page_table_8b.sv
// Directed scoreboard bench for page_table_8b: stimulus pushes expected return value and
// completion cycle, a negedge monitor pops and compares on every LOOKUP_COMPLETE pulse.
module tb_page_table_8b;

   localparam int WL = 4;

   logic       clk;
   logic       rst;
   logic       LOOKUP_RQST;
   logic [2:0] LOOKUP_ADDR;
   logic       LOOKUP_COMPLETE;
   logic [5:0] LOOKUP_RETURN;
   logic       PT_INSERT_RQST;
   logic [3:0] PT_INSERT_INDX;
   logic [5:0] PT_INSERT_ENTRY;

   typedef struct {
      logic [5:0] ret;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc        = 0;
   int   total      = 0;
   int   bad        = 0;
   int   n_complete = 0;

   page_table_8b #(.WALK_LATENCY(WL), .LOOKUP_HALF(1'b1)) dut (
      .clk             (clk),
      .rst             (rst),
      .LOOKUP_RQST     (LOOKUP_RQST),
      .LOOKUP_ADDR     (LOOKUP_ADDR),
      .LOOKUP_COMPLETE (LOOKUP_COMPLETE),
      .LOOKUP_RETURN   (LOOKUP_RETURN),
      .PT_INSERT_RQST  (PT_INSERT_RQST),
      .PT_INSERT_INDX  (PT_INSERT_INDX),
      .PT_INSERT_ENTRY (PT_INSERT_ENTRY)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (LOOKUP_COMPLETE === 1'b1) begin
         n_complete++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_complete actual=%b required=no pulse", LOOKUP_RETURN);
         end else begin
            e = sb.pop_front();
            check("lookup_return", int'(LOOKUP_RETURN), int'(e.ret));
            check("complete_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic lookup(input logic [2:0] a, input logic [5:0] ret, input bit expect_it);
      LOOKUP_RQST = 1'b1;
      LOOKUP_ADDR = a;
      if (expect_it) sb.push_back('{ret: ret, cyc: cyc + 1 + WL});
      @(negedge clk);
      LOOKUP_RQST = 1'b0;
   endtask

   task automatic insert(input logic [3:0] idx, input logic [5:0] val);
      PT_INSERT_RQST  = 1'b1;
      PT_INSERT_INDX  = idx;
      PT_INSERT_ENTRY = val;
      @(negedge clk);
      PT_INSERT_RQST  = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check(name, sb.size(), 0);
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      LOOKUP_RQST = 1'b0;
      LOOKUP_ADDR = 3'b000;
      PT_INSERT_RQST = 1'b0;
      PT_INSERT_INDX = 4'd0;
      PT_INSERT_ENTRY = 6'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_complete", int'(LOOKUP_COMPLETE), 0);
      check("reset_return", int'(LOOKUP_RETURN), 0);

      // Lookup of a never-written entry after reset.
      lookup(3'b101, 6'b000000, 1'b1);
      drain("drain_reset_lookup");

      // Plain insert then lookup; value held afterwards.
      insert(4'd15, 6'b101010);
      lookup(3'b111, 6'b101010, 1'b1);
      drain("drain_insert15");
      repeat (3) @(negedge clk);
      check("hold_return", int'(LOOKUP_RETURN), 6'b101010);
      check("hold_complete_low", int'(LOOKUP_COMPLETE), 0);

      // Insert into the walked entry mid-walk is visible.
      insert(4'd13, 6'b000111);
      lookup(3'b101, 6'b111000, 1'b1);
      @(negedge clk);
      insert(4'd13, 6'b111000);
      drain("drain_midwalk_insert");

      // Insert on the completing edge is forwarded.
      lookup(3'b100, 6'b010101, 1'b1);
      repeat (3) @(negedge clk);
      insert(4'd12, 6'b010101);
      drain("drain_same_edge");

      // Lower-half entry is never returned.
      insert(4'd7, 6'b111111);
      lookup(3'b111, 6'b101010, 1'b1);
      drain("drain_lower_half");

      // Requests during the walk and on the completing edge are dropped.
      lookup(3'b101, 6'b111000, 1'b1);
      LOOKUP_RQST = 1'b1;
      LOOKUP_ADDR = 3'b111;
      repeat (3) @(negedge clk);
      LOOKUP_RQST = 1'b0;
      drain("drain_ignored_rqst");

      // Held request: back-to-back walks, one idle edge between them.
      LOOKUP_RQST = 1'b1;
      LOOKUP_ADDR = 3'b111;
      sb.push_back('{ret: 6'b101010, cyc: cyc + 1 + WL});
      sb.push_back('{ret: 6'b101010, cyc: cyc + 2 + 2 * WL});
      repeat (6) @(negedge clk);
      LOOKUP_RQST = 1'b0;
      drain("drain_held_rqst");

      // Reset mid-walk aborts without a pulse and clears everything.
      lookup(3'b111, 6'b000000, 1'b0);
      @(negedge clk);
      n0 = n_complete;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_no_complete", n_complete - n0, 0);
      check("abort_return_zero", int'(LOOKUP_RETURN), 0);
      lookup(3'b111, 6'b000000, 1'b1);
      drain("drain_post_reset_15");
      lookup(3'b101, 6'b000000, 1'b1);
      drain("drain_post_reset_13");
      lookup(3'b100, 6'b000000, 1'b1);
      drain("drain_post_reset_12");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
